// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped timer: register map, bit positions, reset values.
package timer_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned PRESCALE_W = 16;
  localparam int unsigned CTRL_W     = 3;

  // Byte offsets of the register window
  localparam int unsigned OFF_CTRL     = 32'h00;
  localparam int unsigned OFF_COUNT    = 32'h04;
  localparam int unsigned OFF_COMPARE  = 32'h08;
  localparam int unsigned OFF_STATUS   = 32'h0C;
  localparam int unsigned OFF_PRESCALE = 32'h10;

  // Bit positions inside CTRL and STATUS
  localparam int unsigned CTRL_EN_BIT         = 0;
  localparam int unsigned CTRL_AUTORELOAD_BIT = 1;
  localparam int unsigned CTRL_IRQEN_BIT      = 2;
  localparam int unsigned STATUS_MATCH_BIT    = 0;

  // Packed so that bit0=en, bit1=autoreload, bit2=irqen on the bus
  typedef struct packed {
    logic irqen;
    logic autoreload;
    logic en;
  } ctrl_t;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CTRL,
    SEL_COUNT,
    SEL_COMPARE,
    SEL_STATUS,
    SEL_PRESCALE
  } reg_sel_e;

  localparam ctrl_t                   CTRL_RST     = '0;
  localparam logic [DATA_W-1:0]       COUNT_RST    = 32'h0000_0000;
  localparam logic [DATA_W-1:0]       COMPARE_RST  = 32'hFFFF_FFFF;
  localparam logic [PRESCALE_W-1:0]   PRESCALE_RST = 16'h0000;

endpackage

// File: rtl/timer_prescaler.sv
// Prescale counter: emits a one-cycle tick every (prescale+1) enabled cycles.
module timer_prescaler
  import timer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pc_q;

  // Tick is a pure function of registered state, so it is glitch-free within the cycle
  assign tick = en && (pc_q == prescale);

  // PC advances while enabled, wraps on tick, and is cleared by any CTRL/PRESCALE write
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
    end else if (clr) begin
      pc_q <= '0;
    end else if (en) begin
      if (pc_q == prescale) pc_q <= '0;
      else                  pc_q <= pc_q + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/timer_unit.sv
// Memory-mapped 32-bit timer with prescaler, compare match, autoreload and level interrupt.
module timer_unit
  import timer_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] memaddr,
  input  logic [DATA_W-1:0] memwritedata,
  output logic [DATA_W-1:0] memreaddata,
  output logic              irq
);

  ctrl_t                 ctrl_q, ctrl_d;
  logic [DATA_W-1:0]     count_q, count_d;
  logic [DATA_W-1:0]     compare_q, compare_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  match_q, match_d;

  logic [ADDR_W-1:0] word_addr;
  logic              unused_addr_bits;
  reg_sel_e          sel;
  logic              wr_en;
  logic              tick;
  logic              hit;
  logic              pc_clr;

  // Byte-lane bits are don't-care; decode on the word-aligned offset
  assign word_addr        = {memaddr[ADDR_W-1:2], 2'b00};
  assign unused_addr_bits = ^memaddr[1:0];
  assign wr_en            = cs && memwrite;
  assign pc_clr           = wr_en && ((sel == SEL_CTRL) || (sel == SEL_PRESCALE));
  assign hit              = tick && (count_q == compare_q);

  // Address decode of the register window
  always_comb begin
    sel = SEL_NONE;
    if      (word_addr == ADDR_W'(OFF_CTRL))     sel = SEL_CTRL;
    else if (word_addr == ADDR_W'(OFF_COUNT))    sel = SEL_COUNT;
    else if (word_addr == ADDR_W'(OFF_COMPARE))  sel = SEL_COMPARE;
    else if (word_addr == ADDR_W'(OFF_STATUS))   sel = SEL_STATUS;
    else if (word_addr == ADDR_W'(OFF_PRESCALE)) sel = SEL_PRESCALE;
  end

  timer_prescaler u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .en       (ctrl_q.en),
    .clr      (pc_clr),
    .prescale (prescale_q),
    .tick     (tick)
  );

  // Next-state: tick update first, CPU writes override; hardware MATCH set beats W1C
  always_comb begin
    ctrl_d     = ctrl_q;
    count_d    = count_q;
    compare_d  = compare_q;
    prescale_d = prescale_q;
    match_d    = match_q;

    if (tick) begin
      if (hit && ctrl_q.autoreload) count_d = '0;
      else                          count_d = count_q + DATA_W'(1);
    end

    if (wr_en) begin
      case (sel)
        SEL_CTRL: begin
          ctrl_d.en         = memwritedata[CTRL_EN_BIT];
          ctrl_d.autoreload = memwritedata[CTRL_AUTORELOAD_BIT];
          ctrl_d.irqen      = memwritedata[CTRL_IRQEN_BIT];
        end
        SEL_COUNT:    count_d    = memwritedata;
        SEL_COMPARE:  compare_d  = memwritedata;
        SEL_STATUS:   if (memwritedata[STATUS_MATCH_BIT]) match_d = 1'b0;
        SEL_PRESCALE: prescale_d = memwritedata[PRESCALE_W-1:0];
        default: ;
      endcase
    end

    if (hit) match_d = 1'b1;
  end

  // Register state; irq is registered from next-state so it rises together with MATCH
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= CTRL_RST;
      count_q    <= COUNT_RST;
      compare_q  <= COMPARE_RST;
      prescale_q <= PRESCALE_RST;
      match_q    <= 1'b0;
      irq        <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      prescale_q <= prescale_d;
      match_q    <= match_d;
      irq        <= match_d & ctrl_d.irqen;
    end
  end

  // Zero-latency read mux from current register values
  always_comb begin
    memreaddata = '0;
    if (cs) begin
      case (sel)
        SEL_CTRL:     memreaddata = DATA_W'(ctrl_q);
        SEL_COUNT:    memreaddata = count_q;
        SEL_COMPARE:  memreaddata = compare_q;
        SEL_STATUS:   memreaddata = DATA_W'(match_q);
        SEL_PRESCALE: memreaddata = DATA_W'(prescale_q);
        default:      memreaddata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_unit.sv
// Scoreboard bench for timer_unit: driver pushes expectations, negedge monitor compares.
module tb_timer_unit;

  logic        clk;
  logic        reset;
  logic        cs;
  logic        memwrite;
  logic [4:0]  memaddr;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;
  logic        irq;

  timer_unit #(.ADDR_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .cs           (cs),
    .memwrite     (memwrite),
    .memaddr      (memaddr),
    .memwritedata (memwritedata),
    .memreaddata  (memreaddata),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        irq;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: tick derived from enabled cycles elapsed since the last prescaler clear
  bit          m_en, m_ar, m_ie, m_match;
  logic [31:0] m_count, m_compare;
  int unsigned m_prescale, m_since;

  function automatic void m_reset();
    m_en = 0; m_ar = 0; m_ie = 0; m_match = 0;
    m_count = 32'h0; m_compare = 32'hFFFF_FFFF;
    m_prescale = 0; m_since = 0;
  endfunction

  function automatic logic [31:0] m_read(bit c, logic [4:0] a);
    logic [31:0] v;
    v = 32'h0;
    if (c) begin
      case (a[4:2])
        3'd0: v = {29'h0, m_ie, m_ar, m_en};
        3'd1: v = m_count;
        3'd2: v = m_compare;
        3'd3: v = {31'h0, m_match};
        3'd4: v = m_prescale;
        default: v = 32'h0;
      endcase
    end
    return v;
  endfunction

  function automatic void m_step(bit r, bit c, bit w, logic [4:0] a, logic [31:0] d);
    bit wr, tick, hit;
    int unsigned word;
    if (r) begin
      m_reset();
      return;
    end
    wr   = c && w;
    word = a[4:2];
    tick = m_en && ((m_since % (m_prescale + 1)) == m_prescale);
    hit  = tick && (m_count == m_compare);
    if (m_en) m_since++;
    if (tick) m_count = (hit && m_ar) ? 32'h0 : m_count + 32'h1;
    if (hit) m_match = 1;
    else if (wr && word == 3 && d[0]) m_match = 0;
    if (wr) begin
      case (word)
        0: begin m_en = d[0]; m_ar = d[1]; m_ie = d[2]; m_since = 0; end
        1: m_count = d;
        2: m_compare = d;
        4: begin m_prescale = d[15:0]; m_since = 0; end
        default: ;
      endcase
    end
  endfunction

  // One bus cycle: drive, queue the expected response for this cycle, advance the model
  task automatic cycle(input bit r, input bit c, input bit w, input logic [4:0] a,
                       input logic [31:0] d, input bit use_const, input logic [31:0] cexp,
                       input string tag);
    exp_t e;
    reset = r; cs = c; memwrite = w; memaddr = a; memwritedata = d;
    e.rdata = use_const ? cexp : m_read(c, a);
    e.irq   = m_en === 1'bx ? 1'b0 : (m_match && m_ie);
    e.tag   = tag;
    exp_q.push_back(e);
    @(posedge clk);
    m_step(r, c, w, a, d);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cycle(0, 1, 1, a, d, 0, 32'h0, "wr");
  endtask
  task automatic rd(input logic [4:0] a, input string tag);
    cycle(0, 1, 0, a, 32'h0, 0, 32'h0, tag);
  endtask
  task automatic rdc(input logic [4:0] a, input logic [31:0] x, input string tag);
    cycle(0, 1, 0, a, 32'h0, 1, x, tag);
  endtask
  task automatic rst();
    cycle(1, 1, 0, 5'h00, 32'h0, 0, 32'h0, "rst");
  endtask

  // Monitor: read data is valid every cycle; compare against the queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (memreaddata === e.rdata) n_pass++;
      else $display("FAIL %s memreaddata: got %h expected %h at %0t", e.tag, memreaddata, e.rdata, $time);
      n_checks++;
      if (irq === e.irq) n_pass++;
      else $display("FAIL %s irq: got %b expected %b at %0t", e.tag, irq, e.irq, $time);
    end
  end

  initial begin
    logic [4:0]  a;
    logic [31:0] d;
    bit          c, w, r;

    reset = 1; cs = 0; memwrite = 0; memaddr = 0; memwritedata = 0;
    @(posedge clk);
    m_reset();
    #1;

    // Reset state
    rdc(5'h00, 32'h0, "rst_ctrl");
    rdc(5'h04, 32'h0, "rst_count");
    rdc(5'h08, 32'hFFFF_FFFF, "rst_compare");
    rdc(5'h0C, 32'h0, "rst_status");
    rdc(5'h10, 32'h0, "rst_prescale");

    // Basic count to compare with autoreload and irq
    wr(5'h10, 32'h0);
    wr(5'h08, 32'h3);
    wr(5'h00, 32'h7);
    rdc(5'h04, 32'h0, "seq_c0");
    rdc(5'h04, 32'h1, "seq_c1");
    rdc(5'h04, 32'h2, "seq_c2");
    rdc(5'h04, 32'h3, "seq_c3");
    rdc(5'h04, 32'h0, "seq_reload");
    rdc(5'h0C, 32'h1, "seq_match");

    // Prescale of 2, then freeze with EN=0
    rst();
    wr(5'h10, 32'h2);
    wr(5'h00, 32'h1);
    for (int i = 0; i < 9; i++) rd(5'h04, "presc");
    wr(5'h00, 32'h0);
    for (int i = 0; i < 10; i++) rd(5'h04, "freeze");

    // 32-bit wrap, no spurious match
    rst();
    wr(5'h08, 32'h5);
    wr(5'h04, 32'hFFFF_FFFE);
    wr(5'h00, 32'h1);
    rdc(5'h04, 32'hFFFF_FFFE, "wrap_fe");
    rdc(5'h04, 32'hFFFF_FFFF, "wrap_ff");
    rdc(5'h04, 32'h0, "wrap_0");
    rdc(5'h04, 32'h1, "wrap_1");
    rdc(5'h0C, 32'h0, "wrap_nomatch");

    // Set beats W1C, then a plain W1C clears MATCH and irq
    rst();
    wr(5'h04, 32'd10);
    wr(5'h08, 32'd10);
    wr(5'h00, 32'h5);
    rdc(5'h0C, 32'h0, "w1c_pre");
    wr(5'h04, 32'd10);
    wr(5'h0C, 32'h1);
    rdc(5'h0C, 32'h1, "w1c_setwins");
    wr(5'h00, 32'h4);
    wr(5'h0C, 32'h1);
    rdc(5'h0C, 32'h0, "w1c_clear");

    // CPU COUNT write beats tick; reset with a simultaneous write
    rst();
    wr(5'h00, 32'h1);
    wr(5'h04, 32'h100);
    rdc(5'h04, 32'h100, "cnt_wr_prio");
    cycle(1, 1, 1, 5'h08, 32'h1234, 0, 32'h0, "rst_wr");
    rdc(5'h00, 32'h0, "rst2_ctrl");
    rdc(5'h04, 32'h0, "rst2_count");
    rdc(5'h08, 32'hFFFF_FFFF, "rst2_compare");
    rdc(5'h0C, 32'h0, "rst2_status");
    rdc(5'h10, 32'h0, "rst2_prescale");

    // Unmapped offset, cs=0 read, cs=0 write ignored
    rdc(5'h14, 32'h0, "unmapped");
    cycle(0, 0, 0, 5'h08, 32'h0, 1, 32'h0, "cs0_read");
    cycle(0, 0, 1, 5'h08, 32'hDEAD_BEEF, 1, 32'h0, "cs0_write");
    rdc(5'h08, 32'hFFFF_FFFF, "cs0_nochange");

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      r = ($urandom % 64) == 0;
      c = ($urandom % 4) != 0;
      w = ($urandom % 2) == 0;
      a = 5'($urandom % 32);
      case (a[4:2])
        3'd0: d = $urandom % 8;
        3'd1: d = (($urandom % 2) == 0) ? m_compare - 32'($urandom_range(0, 4)) : $urandom;
        3'd2: d = (($urandom % 2) == 0) ? m_count + 32'($urandom_range(0, 6)) : 32'($urandom_range(0, 20));
        3'd3: d = $urandom;
        3'd4: d = {$urandom, 2'b00} & 32'hFFFF_0003;
        default: d = $urandom;
      endcase
      cycle(r, c, w, a, d, 0, 32'h0, "rand");
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
